// File: rtl/vscpu_boot_ctrl.sv
// vscpu_boot_ctrl: boot sequencer and RAM-port owner for the VerySimpleCPU core.
// Streams a program image from the loader into RAM while holding the CPU in
// reset, releases the CPU, then monitors it until a halt write, watchdog
// timeout or abort ends the run.
module vscpu_boot_ctrl #(
    parameter int unsigned     SIZE        = 14,
    parameter logic [SIZE-1:0] HALT_ADDR   = 14'h3FFF,
    parameter int unsigned     WDOG_CYCLES = 1000000,
    parameter int unsigned     RST_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] load_len,
    input  logic            ld_valid,
    input  logic [31:0]     ld_data,
    output logic            ld_ready,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata,
    output logic            busy,
    output logic            done,
    output logic [1:0]      halt_cause,
    output logic [31:0]     cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_HALT  = 2'd1;
    localparam logic [1:0] CAUSE_WDOG  = 2'd2;
    localparam logic [1:0] CAUSE_ABORT = 2'd3;

    state_t          state;
    state_t          state_nx;
    logic [1:0]      cause_nx;
    logic [SIZE-1:0] len_q;
    logic [SIZE-1:0] word_cnt;
    logic [31:0]     rel_cnt;
    logic            halt_hit;
    logic            wdog_hit;
    logic            last_word;

    assign halt_hit  = cpu_wrEn && (cpu_addr == HALT_ADDR);
    assign wdog_hit  = (WDOG_CYCLES != 0) && (cycle_cnt == 32'(WDOG_CYCLES - 1));
    assign last_word = (word_cnt == len_q - 1'b1);
    assign cpu_rdata = ram_rdata;

    // State register plus the word, release and run-cycle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            word_cnt   <= '0;
            rel_cnt    <= '0;
            cycle_cnt  <= '0;
            halt_cause <= CAUSE_NONE;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_q      <= load_len;
                        word_cnt   <= '0;
                        rel_cnt    <= '0;
                        cycle_cnt  <= '0;
                        halt_cause <= CAUSE_NONE;
                    end
                end
                S_LOAD: begin
                    if (ld_valid && !abort) word_cnt <= word_cnt + 1'b1;
                end
                S_RELEASE: rel_cnt   <= rel_cnt + 32'd1;
                S_RUN:     cycle_cnt <= cycle_cnt + 32'd1;
                default: ;
            endcase
            // Cause is captured only on the transition into DONE, so it holds there
            if (state_nx == S_DONE && state != S_DONE) halt_cause <= cause_nx;
        end
    end

    // Next-state decode; abort outranks halt write, which outranks watchdog
    always_comb begin
        state_nx = state;
        cause_nx = CAUSE_NONE;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = (load_len == '0) ? S_RELEASE : S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_nx = S_DONE;
                    cause_nx = CAUSE_ABORT;
                end else if (ld_valid && last_word) begin
                    state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (abort) begin
                    state_nx = S_DONE;
                    cause_nx = CAUSE_ABORT;
                end else if (rel_cnt == 32'(RST_CYCLES - 1)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx = S_DONE;
                    cause_nx = CAUSE_ABORT;
                end else if (halt_hit) begin
                    state_nx = S_DONE;
                    cause_nx = CAUSE_HALT;
                end else if (wdog_hit) begin
                    state_nx = S_DONE;
                    cause_nx = CAUSE_WDOG;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // RAM port mux and status outputs decoded from the current state
    always_comb begin
        ram_wrEn  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ld_ready  = (state == S_LOAD);
        busy      = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
        done      = (state == S_DONE);
        cpu_rst   = (state != S_RUN);
        case (state)
            S_LOAD: begin
                ram_wrEn  = ld_valid && !abort;
                ram_addr  = word_cnt;
                ram_wdata = ld_data;
            end
            S_RUN: begin
                ram_wrEn  = cpu_wrEn && !abort;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

endmodule
